lever_adc_scheduler: RTL and testbench



---
 rtl/equilibrium_pkg.sv | 17 +
 rtl/lever_sample_convert.sv | 40 ++++
 rtl/lever_adc_scheduler.sv | 128 ++++++++++++
 tb/tb_lever_adc_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/equilibrium_pkg.sv
// Shared types and constants for the lever ADC path: scan FSM states and the 14.2 lever word format.
// Pure declarations, no logic.
package equilibrium_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START0,
    ST_WAIT0,
    ST_START1,
    ST_WAIT1,
    ST_COMMIT
  } lever_scan_state_t;

  localparam int LEVER_ADC_CENTER = 2048;
  localparam int LEVER_FRAC_BITS  = 2;

endpackage

// File: rtl/lever_sample_convert.sv
// Raw ADC code -> signed 14.2 lever word: centre, optional deadband (LEVER_DEADBAND_EN), shift, saturate.
// Combinational, zero latency, no flow control.
module lever_sample_convert
  import equilibrium_pkg::*;
#(
  parameter int ADC_BITS   = 12,
  parameter int ADC_CENTER = LEVER_ADC_CENTER,
  parameter int FRAC_SHIFT = LEVER_FRAC_BITS,
  parameter int OUT_BITS   = 16,
  parameter int DEADBAND   = 8
) (
  input  logic [ADC_BITS-1:0] i_adc_data,
  output logic [OUT_BITS-1:0] o_word
);

  localparam int DW = ADC_BITS + 1;
  localparam int WW = DW + FRAC_SHIFT + OUT_BITS;
  localparam logic [DW-1:0] CENTER_C = DW'(ADC_CENTER);
  localparam logic signed [WW-1:0] MAX_C = {{(WW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_C = ~MAX_C;

  logic signed [DW-1:0] w_d;
  logic signed [DW-1:0] w_db;
  logic signed [WW-1:0] w_wide;

  // One extra bit keeps the centred value exact for every raw code.
  assign w_d = {1'b0, i_adc_data} - CENTER_C;

`ifdef LEVER_DEADBAND_EN
  assign w_db = (int'(w_d) <= DEADBAND && int'(w_d) >= -DEADBAND) ? '0 : w_d;
`else
  assign w_db = w_d;
`endif

  assign w_wide = {{(WW-DW){w_db[DW-1]}}, w_db} << FRAC_SHIFT;

  assign o_word = (w_wide > MAX_C) ? MAX_C[OUT_BITS-1:0] :
                  (w_wide < MIN_C) ? MIN_C[OUT_BITS-1:0] : w_wide[OUT_BITS-1:0];

endmodule

// File: rtl/lever_adc_scheduler.sv
// Scans both levers through one shared ADC per sim_tick and publishes both words together; optional LEVER_DEADBAND_EN.
// Latency: tick->adc_start 1 cycle, last adc_done->words 2 cycles; ADC waits bounded by TIMEOUT_CYCLES, no backpressure.
module lever_adc_scheduler
  import equilibrium_pkg::*;
#(
  parameter int ADC_BITS       = 12,
  parameter int ADC_CENTER     = LEVER_ADC_CENTER,
  parameter int FRAC_SHIFT     = LEVER_FRAC_BITS,
  parameter int OUT_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 50_000,
  parameter int DEADBAND       = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sim_tick,
  input  logic                clear_flags,
  output logic                adc_start,
  output logic                adc_channel,
  input  logic                adc_done,
  input  logic [ADC_BITS-1:0] adc_data,
  output logic [OUT_BITS-1:0] al1Bits,
  output logic [OUT_BITS-1:0] al2Bits,
  output logic                sample_valid,
  output logic [1:0]          timeout_err,
  output logic                overrun_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT_CYCLES);

  lever_scan_state_t   r_state;
  logic [CNT_W-1:0]    r_tmo_cnt;
  logic [OUT_BITS-1:0] r_shadow0, r_shadow1, r_al1, r_al2;
  logic                r_adc_start, r_adc_channel, r_sample_valid, r_overrun;
  logic [1:0]          r_timeout;

  logic [OUT_BITS-1:0] w_conv;
  logic                w_waiting, w_tmo_hit, w_step;
  logic [1:0]          w_tmo_set;
  logic                w_ovr_set;

  lever_sample_convert #(
    .ADC_BITS   (ADC_BITS),
    .ADC_CENTER (ADC_CENTER),
    .FRAC_SHIFT (FRAC_SHIFT),
    .OUT_BITS   (OUT_BITS),
    .DEADBAND   (DEADBAND)
  ) u_convert (
    .i_adc_data (adc_data),
    .o_word     (w_conv)
  );

  assign w_waiting = (r_state == ST_WAIT0) || (r_state == ST_WAIT1);
  assign w_tmo_hit = w_waiting && !adc_done && (r_tmo_cnt == TMO_C);
  // A timeout advances the scan exactly like a (data-less) adc_done.
  assign w_step    = w_waiting && (adc_done || w_tmo_hit);
  assign w_tmo_set = {w_tmo_hit && (r_state == ST_WAIT1), w_tmo_hit && (r_state == ST_WAIT0)};
  assign w_ovr_set = sim_tick && (r_state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_tmo_cnt      <= '0;
      r_shadow0      <= '0;
      r_shadow1      <= '0;
      r_al1          <= '0;
      r_al2          <= '0;
      r_adc_start    <= 1'b0;
      r_adc_channel  <= 1'b0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_timeout      <= 2'b00;
    end else begin
      r_adc_start    <= 1'b0;
      r_sample_valid <= 1'b0;
      r_overrun      <= w_ovr_set | (r_overrun & ~clear_flags);
      r_timeout      <= w_tmo_set | (r_timeout & {2{~clear_flags}});
      case (r_state)
        ST_IDLE: begin
          if (sim_tick) begin
            r_state       <= ST_START0;
            r_adc_start   <= 1'b1;
            r_adc_channel <= 1'b0;
          end
        end
        ST_START0: begin
          r_state   <= ST_WAIT0;
          r_tmo_cnt <= '0;
        end
        ST_WAIT0: begin
          if (adc_done) r_shadow0 <= w_conv;
          if (w_step) begin
            r_state       <= ST_START1;
            r_adc_start   <= 1'b1;
            r_adc_channel <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        ST_START1: begin
          r_state   <= ST_WAIT1;
          r_tmo_cnt <= '0;
        end
        ST_WAIT1: begin
          if (adc_done) r_shadow1 <= w_conv;
          if (w_step) r_state <= ST_COMMIT;
          else        r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
        ST_COMMIT: begin
          r_al1          <= r_shadow0;
          r_al2          <= r_shadow1;
          r_sample_valid <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign adc_start    = r_adc_start;
  assign adc_channel  = r_adc_channel;
  assign al1Bits      = r_al1;
  assign al2Bits      = r_al2;
  assign sample_valid = r_sample_valid;
  assign timeout_err  = r_timeout;
  assign overrun_err  = r_overrun;

endmodule

// File: tb/tb_lever_adc_scheduler.sv
// Bench for lever_adc_scheduler: scoreboard of expected lever words, one task per scenario.
// A second instance with OUT_BITS=12 shares the stimulus to exercise saturation.
module tb_lever_adc_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sim_tick = 1'b0;
  logic        clear_flags = 1'b0;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;

  logic        adc_start, adc_channel, sample_valid, overrun_err;
  logic [15:0] al1Bits, al2Bits;
  logic [1:0]  timeout_err;

  logic        n_adc_start, n_adc_channel, n_sample_valid, n_overrun_err;
  logic [11:0] al1n, al2n;
  logic [1:0]  n_timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { logic [15:0] a1; logic [15:0] a2; } exp_t;
  exp_t exp_q[$];
  logic [15:0] last1 = '0, last2 = '0;

  always #5 clock = ~clock;

  lever_adc_scheduler #(.TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset(reset), .sim_tick(sim_tick), .clear_flags(clear_flags),
    .adc_start(adc_start), .adc_channel(adc_channel), .adc_done(adc_done), .adc_data(adc_data),
    .al1Bits(al1Bits), .al2Bits(al2Bits), .sample_valid(sample_valid),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  lever_adc_scheduler #(.OUT_BITS(12), .TIMEOUT_CYCLES(100)) dut_narrow (
    .clock(clock), .reset(reset), .sim_tick(sim_tick), .clear_flags(clear_flags),
    .adc_start(n_adc_start), .adc_channel(n_adc_channel), .adc_done(adc_done), .adc_data(adc_data),
    .al1Bits(al1n), .al2Bits(al2n), .sample_valid(n_sample_valid),
    .timeout_err(n_timeout_err), .overrun_err(n_overrun_err)
  );

  function automatic logic [15:0] conv(input int raw, input int ob);
    int d, v, mx;
    d = raw - 2048;
`ifdef LEVER_DEADBAND_EN
    if (d <= 8 && d >= -8) d = 0;
`endif
    v  = d * 4;
    mx = (1 << (ob - 1)) - 1;
    if (v > mx) v = mx;
    if (v < -mx - 1) v = -mx - 1;
    return 16'(v);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input int raw0, input int raw1, input bit keep2);
    exp_t e;
    e.a1 = conv(raw0, 16);
    e.a2 = keep2 ? last2 : conv(raw1, 16);
    last1 = e.a1;
    last2 = e.a2;
    exp_q.push_back(e);
  endtask

  // Runs one scan: answers each adc_start two cycles later when enabled, bounded to 400 cycles.
  task automatic do_scan(input int d0, input int d1, input bit ans0, input bit ans1,
                         input int tick2_at, input int clr_at,
                         output logic [15:0] o1, output logic [15:0] o2,
                         output logic [11:0] n1, output logic [11:0] n2,
                         output int nvalid, output int nstart, output int nearly);
    int pend, pch, quiet;
    logic [15:0] p1, p2;
    pend = -1; pch = 0; quiet = 0; nvalid = 0; nstart = 0; nearly = 0;
    o1 = 'x; o2 = 'x; n1 = 'x; n2 = 'x;
    p1 = al1Bits; p2 = al2Bits;
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    for (int i = 0; i < 400; i++) begin
      adc_done    = 1'b0;
      sim_tick    = (i == tick2_at);
      clear_flags = (i == clr_at);
      if (adc_start) begin
        nstart++;
        if ((!adc_channel && ans0) || (adc_channel && ans1)) begin
          pend = 2;
          pch  = int'(adc_channel);
        end
      end
      if (sample_valid) begin
        nvalid++;
        o1 = al1Bits; o2 = al2Bits; n1 = al1n; n2 = al2n;
      end else if (al1Bits !== p1 || al2Bits !== p2) begin
        nearly++;
      end
      p1 = al1Bits; p2 = al2Bits;
      if (pend == 0) begin
        adc_done = 1'b1;
        adc_data = 12'(pch != 0 ? d1 : d0);
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (nvalid > 0) quiet++;
      if (quiet > 5) break;
      step();
    end
    adc_done = 1'b0; sim_tick = 1'b0; clear_flags = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    n_checks++; if (al1Bits !== 16'd0 || al2Bits !== 16'd0) $display("FAIL reset_words got %0d/%0d want 0/0", al1Bits, al2Bits); else n_pass++;
    n_checks++; if (adc_start !== 1'b0 || adc_channel !== 1'b0) $display("FAIL reset_adc got start=%b ch=%b want 0/0", adc_start, adc_channel); else n_pass++;
    n_checks++; if (sample_valid !== 1'b0 || timeout_err !== 2'b00 || overrun_err !== 1'b0) $display("FAIL reset_flags got v=%b t=%b o=%b want 0", sample_valid, timeout_err, overrun_err); else n_pass++;
  endtask

  task automatic test_nominal();
    logic [15:0] o1, o2; logic [11:0] n1, n2; int nv, ns, ne; exp_t e;
    push_exp(2048, 2148, 1'b0);
    do_scan(2048, 2148, 1'b1, 1'b1, -1, -1, o1, o2, n1, n2, nv, ns, ne);
    e = exp_q.pop_front();
    n_checks++; if (o1 !== e.a1) $display("FAIL nominal_al1 got %0d want %0d", $signed(o1), $signed(e.a1)); else n_pass++;
    n_checks++; if (o2 !== e.a2) $display("FAIL nominal_al2 got %0d want %0d", $signed(o2), $signed(e.a2)); else n_pass++;
    n_checks++; if (nv !== 1 || ns !== 2) $display("FAIL nominal_counts got valid=%0d start=%0d want 1/2", nv, ns); else n_pass++;
    n_checks++; if (ne !== 0) $display("FAIL nominal_same_cycle got %0d off-pulse word changes want 0", ne); else n_pass++;
  endtask

  task automatic test_timing();
    exp_t e;
    push_exp(2058, 2038, 1'b0);
    sim_tick = 1'b1; step(); sim_tick = 1'b0;
    n_checks++; if (adc_start !== 1'b1 || adc_channel !== 1'b0) $display("FAIL tick_to_start got start=%b ch=%b want 1/0", adc_start, adc_channel); else n_pass++;
    step();
    n_checks++; if (adc_start !== 1'b0) $display("FAIL start_one_cycle got %b want 0", adc_start); else n_pass++;
    adc_done = 1'b1; adc_data = 12'd2058; step(); adc_done = 1'b0;
    n_checks++; if (adc_start !== 1'b1 || adc_channel !== 1'b1) $display("FAIL done0_to_start1 got start=%b ch=%b want 1/1", adc_start, adc_channel); else n_pass++;
    step(); step();
    adc_done = 1'b1; adc_data = 12'd2038; step(); adc_done = 1'b0;
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL commit_cycle_valid got %b want 0", sample_valid); else n_pass++;
    step();
    e = exp_q.pop_front();
    n_checks++; if (sample_valid !== 1'b1) $display("FAIL done1_to_valid got %b want 1", sample_valid); else n_pass++;
    n_checks++; if (al1Bits !== e.a1 || al2Bits !== e.a2) $display("FAIL timing_words got %0d/%0d want %0d/%0d", $signed(al1Bits), $signed(al2Bits), $signed(e.a1), $signed(e.a2)); else n_pass++;
    repeat (3) step();
  endtask

  task automatic test_extremes();
    logic [15:0] o1, o2; logic [11:0] n1, n2; int nv, ns, ne; exp_t e;
    push_exp(0, 4095, 1'b0);
    do_scan(0, 4095, 1'b1, 1'b1, -1, -1, o1, o2, n1, n2, nv, ns, ne);
    e = exp_q.pop_front();
    n_checks++; if (o1 !== e.a1 || o2 !== e.a2) $display("FAIL extremes_wide got %0d/%0d want %0d/%0d", $signed(o1), $signed(o2), $signed(e.a1), $signed(e.a2)); else n_pass++;
    n_checks++; if (n1 !== 12'h800 || n2 !== 12'h7FF) $display("FAIL extremes_narrow got %0d/%0d want -2048/2047", $signed(n1), $signed(n2)); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [15:0] o1, o2; logic [11:0] n1, n2; int nv, ns, ne; exp_t e;
    push_exp(2100, 0, 1'b1);
    do_scan(2100, 0, 1'b1, 1'b0, -1, -1, o1, o2, n1, n2, nv, ns, ne);
    e = exp_q.pop_front();
    n_checks++; if (timeout_err !== 2'b10) $display("FAIL timeout_flag got %b want 10", timeout_err); else n_pass++;
    n_checks++; if (nv !== 1) $display("FAIL timeout_valid got %0d want 1", nv); else n_pass++;
    n_checks++; if (o1 !== e.a1 || o2 !== e.a2) $display("FAIL timeout_words got %0d/%0d want %0d/%0d", $signed(o1), $signed(o2), $signed(e.a1), $signed(e.a2)); else n_pass++;
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    n_checks++; if (timeout_err !== 2'b00) $display("FAIL timeout_clear got %b want 00", timeout_err); else n_pass++;
  endtask

  task automatic test_overrun();
    logic [15:0] o1, o2; logic [11:0] n1, n2; int nv, ns, ne, extra; exp_t e;
    push_exp(1000, 3000, 1'b0);
    // Second tick lands in WAIT0 together with clear_flags: the set must win.
    do_scan(1000, 3000, 1'b1, 1'b1, 1, 1, o1, o2, n1, n2, nv, ns, ne);
    e = exp_q.pop_front();
    extra = 0;
    repeat (5) begin step(); if (adc_start) extra++; end
    n_checks++; if (overrun_err !== 1'b1) $display("FAIL overrun_set got %b want 1", overrun_err); else n_pass++;
    n_checks++; if (nv !== 1 || ns !== 2 || extra !== 0) $display("FAIL overrun_single_scan got valid=%0d start=%0d extra=%0d want 1/2/0", nv, ns, extra); else n_pass++;
    n_checks++; if (o1 !== e.a1 || o2 !== e.a2) $display("FAIL overrun_words got %0d/%0d want %0d/%0d", $signed(o1), $signed(o2), $signed(e.a1), $signed(e.a2)); else n_pass++;
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    n_checks++; if (overrun_err !== 1'b0) $display("FAIL overrun_clear got %b want 0", overrun_err); else n_pass++;
  endtask

  task automatic test_deadband();
    logic [15:0] o1, o2; logic [11:0] n1, n2; int nv, ns, ne; exp_t e;
    push_exp(2053, 2057, 1'b0);
    do_scan(2053, 2057, 1'b1, 1'b1, -1, -1, o1, o2, n1, n2, nv, ns, ne);
    e = exp_q.pop_front();
    n_checks++; if (o1 !== e.a1 || o2 !== e.a2) $display("FAIL deadband_words got %0d/%0d want %0d/%0d", $signed(o1), $signed(o2), $signed(e.a1), $signed(e.a2)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] o1, o2; logic [11:0] n1, n2; int nv, ns, ne; exp_t e;
    int r0[3], r1[3];
    for (int k = 0; k < 3; k++) begin
      r0[k] = int'($urandom_range(0, 4095));
      r1[k] = int'($urandom_range(0, 4095));
      push_exp(r0[k], r1[k], 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      do_scan(r0[k], r1[k], 1'b1, 1'b1, -1, -1, o1, o2, n1, n2, nv, ns, ne);
      e = exp_q.pop_front();
      n_checks++; if (o1 !== e.a1 || o2 !== e.a2 || nv !== 1) $display("FAIL b2b_%0d got %0d/%0d valid=%0d want %0d/%0d valid=1", k, $signed(o1), $signed(o2), nv, $signed(e.a1), $signed(e.a2)); else n_pass++;
    end
  endtask

  task automatic test_midscan_reset();
    int ns, nv;
    sim_tick = 1'b1; step(); sim_tick = 1'b0;
    step();
    adc_done = 1'b1; adc_data = 12'd3000; step(); adc_done = 1'b0;
    step();
    reset = 1'b1; step(); reset = 1'b0;
    adc_done = 1'b1; adc_data = 12'd4095; step(); adc_done = 1'b0;
    ns = 0; nv = 0;
    repeat (10) begin
      if (adc_start) ns++;
      if (sample_valid) nv++;
      step();
    end
    n_checks++; if (ns !== 0 || nv !== 0) $display("FAIL midreset_activity got start=%0d valid=%0d want 0/0", ns, nv); else n_pass++;
    n_checks++; if (al1Bits !== 16'd0 || al2Bits !== 16'd0 || adc_channel !== 1'b0) $display("FAIL midreset_outputs got %0d/%0d ch=%b want 0/0/0", al1Bits, al2Bits, adc_channel); else n_pass++;
    n_checks++; if (timeout_err !== 2'b00 || overrun_err !== 1'b0) $display("FAIL midreset_flags got t=%b o=%b want 0", timeout_err, overrun_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timing();
    test_extremes();
    test_timeout();
    test_overrun();
    test_deadband();
    test_back_to_back();
    test_midscan_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
